// File: rtl/core_dbg_apb_master_if.sv
// Bundle of debug request/response handshake and APB master bus signals.
// The master modport is the bridge's view; the slave modport is the far side.
interface core_dbg_apb_master_if #(
    parameter int unsigned APB_ADDR_WIDTH  = 5,
    parameter int unsigned APB_WDATA_WIDTH = 32,
    parameter int unsigned APB_RDATA_WIDTH = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr_rd;
    logic [APB_ADDR_WIDTH-1:0]  req_addr;
    logic [APB_WDATA_WIDTH-1:0] req_wdata;
    logic [3:0]                 req_wstrobe;
    logic                       rsp_valid;
    logic [APB_RDATA_WIDTH-1:0] rsp_rdata;
    logic                       rsp_err;
    logic [APB_ADDR_WIDTH-1:0]  addr;
    logic                       sel;
    logic                       enable;
    logic                       wr_rd;
    logic [APB_WDATA_WIDTH-1:0] wdata;
    logic [3:0]                 wstrobe;
    logic                       ready;
    logic [APB_RDATA_WIDTH-1:0] rdata;

    modport master (
        input  req_valid, req_wr_rd, req_addr, req_wdata, req_wstrobe, ready, rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               addr, sel, enable, wr_rd, wdata, wstrobe
    );

    modport slave (
        output req_valid, req_wr_rd, req_addr, req_wdata, req_wstrobe, ready, rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               addr, sel, enable, wr_rd, wdata, wstrobe
    );
endinterface

// File: rtl/core_dbg_apb_master.sv
// Debug-request to APB master bridge: one transfer at a time, IDLE/SETUP/ACCESS/RESP,
// with an ACCESS-phase timeout that aborts a stuck slave and flags rsp_err.
module core_dbg_apb_master #(
    parameter int unsigned APB_ADDR_WIDTH  = 5,
    parameter int unsigned APB_WDATA_WIDTH = 32,
    parameter int unsigned APB_RDATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    core_dbg_apb_master_if.master bus
);
    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned WW    = APB_WDATA_WIDTH;
    localparam int unsigned RW    = APB_RDATA_WIDTH;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic            sel_q,       sel_d;
    logic            enable_q,    enable_d;
    logic            wr_rd_q,     wr_rd_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [WW-1:0]   wdata_q,     wdata_d;
    logic [3:0]      wstrobe_q,   wstrobe_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;

    // Next-state and registered-output logic; everything holds unless a transition says otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrobe_d   = wstrobe_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_rd_d     = bus.req_wr_rd;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    wstrobe_d   = bus.req_wr_rd ? bus.req_wstrobe : 4'h0;
                    sel_d       = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                enable_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready on the terminal-count edge still completes normally.
                if (bus.ready) begin
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = wr_rd_q ? '0 : bus.rdata;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d       = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrobe_q   <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrobe_q   <= wstrobe_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.addr      = addr_q;
    assign bus.sel       = sel_q;
    assign bus.enable    = enable_q;
    assign bus.wr_rd     = wr_rd_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrobe   = wstrobe_q;
endmodule
